// File: rtl/interleaver_pingpong_ctrl.sv
// Ping-pong frame-buffer scheduler between the interleaver write and read engines.
// Optional statistics counters are built when INTLV_CTRL_STATS_EN is defined.
module interleaver_pingpong_ctrl #(
    parameter int ROW_NUMBER = 10,
    parameter int COL_NUMBER = 7,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_REQ,
    output logic             WR_GRANT,
    output logic             WR_SEL,
    input  logic             WR_DONE,
    output logic             RD_START,
    output logic             RD_SEL,
    input  logic             RD_ACK,
    output logic             BUSY,
    output logic             PROTO_ERR,
    output logic [CNT_W-1:0] FRAME_CNT,
    output logic [CNT_W-1:0] STALL_CNT
);

    if (ROW_NUMBER < 1 || COL_NUMBER < 1) begin : g_bad_geometry
        $error("interleaver geometry must be at least 1x1");
    end

    typedef enum logic [1:0] {
        BUF_FREE  = 2'd0,
        BUF_FILL  = 2'd1,
        BUF_FULL  = 2'd2,
        BUF_DRAIN = 2'd3
    } buf_state_t;

    typedef enum logic { W_IDLE = 1'b0, W_ACTIVE = 1'b1 } w_state_t;
    typedef enum logic { R_IDLE = 1'b0, R_ACTIVE = 1'b1 } r_state_t;

    w_state_t   w_q, w_d;
    r_state_t   r_q, r_d;
    buf_state_t buf_q [2];
    buf_state_t buf_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_sel_d, rd_sel_d, rd_start_d, busy_d, err_d;

    // Handshake: WR_REQ is a level; WR_GRANT stays high from grant until WR_DONE is sampled.
    // WR_DONE, RD_ACK and RD_START are single-cycle pulses; stray pulses are dropped and flagged.
    always_comb begin
        w_d        = w_q;
        r_d        = r_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        buf_d[0]   = buf_q[0];
        buf_d[1]   = buf_q[1];
        wr_sel_d   = WR_SEL;
        rd_sel_d   = RD_SEL;
        rd_start_d = 1'b0;
        err_d      = PROTO_ERR;

        unique case (w_q)
            W_IDLE: begin
                if (WR_DONE) err_d = 1'b1;
                if (WR_REQ && buf_q[wr_ptr_q] == BUF_FREE) begin
                    buf_d[wr_ptr_q] = BUF_FILL;
                    wr_sel_d        = wr_ptr_q;
                    w_d             = W_ACTIVE;
                end
            end
            W_ACTIVE: begin
                if (WR_DONE) begin
                    buf_d[wr_ptr_q] = BUF_FULL;
                    wr_ptr_d        = ~wr_ptr_q;
                    w_d             = W_IDLE;
                end
            end
            default: w_d = W_IDLE;
        endcase

        // The write and read sides always touch buffers in different states, so never the same one.
        unique case (r_q)
            R_IDLE: begin
                if (RD_ACK) err_d = 1'b1;
                if (buf_q[rd_ptr_q] == BUF_FULL) begin
                    buf_d[rd_ptr_q] = BUF_DRAIN;
                    rd_sel_d        = rd_ptr_q;
                    rd_start_d      = 1'b1;
                    r_d             = R_ACTIVE;
                end
            end
            R_ACTIVE: begin
                if (RD_ACK) begin
                    buf_d[rd_ptr_q] = BUF_FREE;
                    rd_ptr_d        = ~rd_ptr_q;
                    r_d             = R_IDLE;
                end
            end
            default: r_d = R_IDLE;
        endcase

        busy_d = (buf_d[0] != BUF_FREE) || (buf_d[1] != BUF_FREE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            w_q       <= W_IDLE;
            r_q       <= R_IDLE;
            buf_q[0]  <= BUF_FREE;
            buf_q[1]  <= BUF_FREE;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            WR_GRANT  <= 1'b0;
            WR_SEL    <= 1'b0;
            RD_START  <= 1'b0;
            RD_SEL    <= 1'b0;
            BUSY      <= 1'b0;
            PROTO_ERR <= 1'b0;
        end else begin
            w_q       <= w_d;
            r_q       <= r_d;
            buf_q[0]  <= buf_d[0];
            buf_q[1]  <= buf_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            WR_GRANT  <= (w_d == W_ACTIVE);
            WR_SEL    <= wr_sel_d;
            RD_START  <= rd_start_d;
            RD_SEL    <= rd_sel_d;
            BUSY      <= busy_d;
            PROTO_ERR <= err_d;
        end
    end

`ifdef INTLV_CTRL_STATS_EN
    logic ack_accept;
    logic stall;

    assign ack_accept = (r_q == R_ACTIVE) && RD_ACK;
    assign stall      = (w_q == W_IDLE) && WR_REQ && (buf_q[wr_ptr_q] != BUF_FREE);

    // Frame count wraps; stall count saturates so long stalls stay visible.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            FRAME_CNT <= '0;
            STALL_CNT <= '0;
        end else begin
            if (ack_accept) FRAME_CNT <= FRAME_CNT + 1'b1;
            if (stall && STALL_CNT != '1) STALL_CNT <= STALL_CNT + 1'b1;
        end
    end
`else
    assign FRAME_CNT = '0;
    assign STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// Directed bench for interleaver_pingpong_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_interleaver_pingpong_ctrl;

    localparam int CNT_W = 16;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             WR_REQ, WR_DONE, RD_ACK;
    logic             WR_GRANT, WR_SEL, RD_START, RD_SEL, BUSY, PROTO_ERR;
    logic [CNT_W-1:0] FRAME_CNT, STALL_CNT;

    int checks = 0;
    int errors = 0;

    // exp_out = {WR_GRANT, WR_SEL, RD_START, RD_SEL, BUSY, PROTO_ERR}
    typedef struct {
        logic       wr_req;
        logic       wr_done;
        logic       rd_ack;
        logic [5:0] exp_out;
    } vec_t;

    vec_t tbl [15];
    logic exp_q [$];

    interleaver_pingpong_ctrl #(
        .ROW_NUMBER(10),
        .COL_NUMBER(7),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .WR_REQ   (WR_REQ),
        .WR_GRANT (WR_GRANT),
        .WR_SEL   (WR_SEL),
        .WR_DONE  (WR_DONE),
        .RD_START (RD_START),
        .RD_SEL   (RD_SEL),
        .RD_ACK   (RD_ACK),
        .BUSY     (BUSY),
        .PROTO_ERR(PROTO_ERR),
        .FRAME_CNT(FRAME_CNT),
        .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [5:0] outs();
        return {WR_GRANT, WR_SEL, RD_START, RD_SEL, BUSY, PROTO_ERR};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET   = 1'b1;
        WR_REQ  = 1'b0;
        WR_DONE = 1'b0;
        RD_ACK  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        check("reset_outs", {26'd0, outs()}, 32'd0);
        check("reset_frame_cnt", {16'd0, FRAME_CNT}, 32'd0);
        check("reset_stall_cnt", {16'd0, STALL_CNT}, 32'd0);
    endtask

    int high_cnt;
    int wcnt, rcnt, acks, coinc;
    logic ractive;

    initial begin
        RESET   = 1'b1;
        WR_REQ  = 1'b0;
        WR_DONE = 1'b0;
        RD_ACK  = 1'b0;

        // Two frames through both buffers, a stall on a draining buffer, then drain to empty.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 6'b100010};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 6'b100010};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 6'b000010};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 6'b111010};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 6'b110010};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 6'b010010};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 6'b010010};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 6'b010010};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 6'b101110};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 6'b000110};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 6'b000110};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 6'b001010};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 6'b000000};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 6'b000000};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            WR_REQ  = tbl[i].wr_req;
            WR_DONE = tbl[i].wr_done;
            RD_ACK  = tbl[i].rd_ack;
            step();
            check($sformatf("vec%0d", i), {26'd0, outs()}, {26'd0, tbl[i].exp_out});
        end

        // Both buffers occupied: writer stalls 20 cycles, then re-granted buffer 0 two edges after RD_ACK.
        do_reset();
        WR_REQ = 1'b1;
        step();
        WR_DONE = 1'b1;
        step();
        WR_DONE = 1'b0;
        step();
        WR_DONE = 1'b1;
        step();
        WR_DONE = 1'b0;
        check("both_used", {26'd0, outs()}, 32'b010010);
        high_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (WR_GRANT) high_cnt++;
        end
        check("stall_no_grant", high_cnt, 0);
`ifdef INTLV_CTRL_STATS_EN
        check("stall_cnt", {16'd0, STALL_CNT}, 32'd20);
`else
        check("stall_cnt", {16'd0, STALL_CNT}, 32'd0);
`endif
        RD_ACK = 1'b1;
        step();
        RD_ACK = 1'b0;
        check("ack_edge", {26'd0, outs()}, 32'b010010);
        step();
        check("regrant_sel0", {26'd0, outs()}, 32'b101110);

        // Streaming with coincident WR_DONE/RD_ACK; expected read order 0,1,0,1,0,1.
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(i[0]);
        WR_REQ  = 1'b1;
        wcnt    = 0;
        rcnt    = 0;
        acks    = 0;
        coinc   = 0;
        ractive = 1'b0;
        for (int cyc = 0; cyc < 300 && acks < 6; cyc++) begin
            step();
            if (RD_ACK) acks++;
            WR_DONE = 1'b0;
            RD_ACK  = 1'b0;
            if (RD_START) begin
                if (exp_q.size() == 0) check("stream_extra_start", 32'd1, 32'd0);
                else check("stream_rd_sel", {31'd0, RD_SEL}, {31'd0, exp_q.pop_front()});
                ractive = 1'b1;
                rcnt    = 0;
            end
            if (WR_GRANT) begin
                wcnt++;
                if (wcnt == 3) begin
                    WR_DONE = 1'b1;
                    wcnt    = 0;
                end
            end
            if (ractive) begin
                rcnt++;
                if (rcnt == 3) begin
                    RD_ACK  = 1'b1;
                    ractive = 1'b0;
                end
            end
            if (WR_DONE && RD_ACK) coinc++;
        end
        WR_REQ  = 1'b0;
        WR_DONE = 1'b0;
        RD_ACK  = 1'b0;
        check("stream_acks", acks, 6);
        check("stream_starts_left", exp_q.size(), 0);
        check("stream_coincident", coinc, 6);
        check("stream_proto_err", {31'd0, PROTO_ERR}, 32'd0);
`ifdef INTLV_CTRL_STATS_EN
        check("frame_cnt", {16'd0, FRAME_CNT}, 32'd6);
`else
        check("frame_cnt", {16'd0, FRAME_CNT}, 32'd0);
`endif

        // Stray RD_ACK in R_IDLE: flagged, sticky, no state change.
        do_reset();
        RD_ACK = 1'b1;
        step();
        RD_ACK = 1'b0;
        check("stray_ack", {26'd0, outs()}, 32'b000001);
        step();
        step();
        check("stray_ack_sticky", {26'd0, outs()}, 32'b000001);

        // Stray WR_DONE in W_IDLE: flagged, and buffer 0 is still the next one granted.
        do_reset();
        WR_DONE = 1'b1;
        step();
        WR_DONE = 1'b0;
        check("stray_done", {26'd0, outs()}, 32'b000001);
        WR_REQ = 1'b1;
        step();
        check("stray_done_state_kept", {26'd0, outs()}, 32'b100011);

        // Asynchronous reset while buffer 0 drains and buffer 1 fills.
        do_reset();
        WR_REQ = 1'b1;
        step();
        WR_DONE = 1'b1;
        step();
        WR_DONE = 1'b0;
        step();
        check("pre_reset", {26'd0, outs()}, 32'b111010);
        #2;
        RESET = 1'b1;
        #1;
        check("async_reset_outs", {26'd0, outs()}, 32'd0);
        check("async_reset_cnts", {FRAME_CNT, STALL_CNT}, 32'd0);
        #1;
        RESET = 1'b0;
        step();
        check("post_reset_grant", {26'd0, outs()}, 32'b100010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
